// File: rtl/bidir_pad_seq_pkg.sv
// Shared state encoding and default parameters for the bidirectional pad sequencer.
package bidir_pad_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        TA     = 2'd2,
        SAMPLE = 2'd3
    } state_t;

    localparam int unsigned DEF_WIDTH          = 8;
    localparam int unsigned DEF_TA_CYCLES      = 2;
    localparam int unsigned SYNC_SAMPLE_CYCLES = 3;

endpackage

// File: rtl/bidir_pad_seq_pad_sync.sv
// Two-flop synchronizer for the pad input bus; only built when BIDIR_PAD_SEQ_SYNC_EN is defined.
`ifdef BIDIR_PAD_SEQ_SYNC_EN
module pad_sync
    import bidir_pad_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             C,
    input  logic             R,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge C) begin
        if (R) begin
            meta <= '0;
            Q    <= '0;
        end else begin
            meta <= D;
            Q    <= meta;
        end
    end

endmodule
`endif

// File: rtl/bidir_pad_seq.sv
// Tri-state pad command sequencer: one-cycle drive plus turnaround for writes, sampled reads.
// Macro BIDIR_PAD_SEQ_SYNC_EN adds a 2-flop synchronizer on PAD_O and stretches SAMPLE to 3 cycles.
module bidir_pad_seq
    import bidir_pad_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned TA_CYCLES = DEF_TA_CYCLES
) (
    input  logic             C,
    input  logic             R,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic             CMD_WR,
    input  logic [WIDTH-1:0] CMD_DATA,
    output logic             RD_VALID,
    output logic [WIDTH-1:0] RD_DATA,
    output logic [WIDTH-1:0] PAD_I,
    output logic [WIDTH-1:0] PAD_T,
    input  logic [WIDTH-1:0] PAD_O
);

    localparam int unsigned CW = (TA_CYCLES == 0) ? 1 : $clog2(TA_CYCLES + 1);

    state_t          state;
    logic [CW-1:0]   ta_cnt;
    logic [WIDTH-1:0] pad_s;
    logic            samp_last;

`ifdef BIDIR_PAD_SEQ_SYNC_EN
    logic [1:0] samp_cnt;

    pad_sync #(.WIDTH(WIDTH)) u_pad_sync (
        .C (C),
        .R (R),
        .D (PAD_O),
        .Q (pad_s)
    );

    assign samp_last = (samp_cnt == 2'(SYNC_SAMPLE_CYCLES - 1));
`else
    assign pad_s     = PAD_O;
    assign samp_last = 1'b1;
`endif

    always_ff @(posedge C) begin
        if (R) begin
            state     <= IDLE;
            PAD_T     <= '1;
            PAD_I     <= '0;
            RD_DATA   <= '0;
            RD_VALID  <= 1'b0;
            CMD_READY <= 1'b0;
            ta_cnt    <= '0;
`ifdef BIDIR_PAD_SEQ_SYNC_EN
            samp_cnt  <= '0;
`endif
        end else begin
            RD_VALID <= 1'b0;
            case (state)
                IDLE: begin
                    CMD_READY <= 1'b1;
                    if (CMD_VALID && CMD_READY) begin
                        CMD_READY <= 1'b0;
                        if (CMD_WR) begin
                            state <= DRIVE;
                            PAD_I <= CMD_DATA;
                            PAD_T <= '0;
                        end else begin
                            state <= SAMPLE;
                            PAD_T <= '1;
`ifdef BIDIR_PAD_SEQ_SYNC_EN
                            samp_cnt <= '0;
`endif
                        end
                    end
                end
                DRIVE: begin
                    PAD_T <= '1;
                    if (TA_CYCLES == 0) begin
                        state     <= IDLE;
                        CMD_READY <= 1'b1;
                    end else begin
                        state  <= TA;
                        ta_cnt <= CW'(TA_CYCLES);
                    end
                end
                TA: begin
                    // Counter holds the remaining TA cycles including the current one; saturates at 0.
                    if (ta_cnt == CW'(1) || ta_cnt == '0) begin
                        ta_cnt    <= '0;
                        state     <= IDLE;
                        CMD_READY <= 1'b1;
                    end else begin
                        ta_cnt <= ta_cnt - CW'(1);
                    end
                end
                SAMPLE: begin
                    if (samp_last) begin
                        RD_DATA   <= pad_s;
                        RD_VALID  <= 1'b1;
                        state     <= IDLE;
                        CMD_READY <= 1'b1;
                    end
`ifdef BIDIR_PAD_SEQ_SYNC_EN
                    else begin
                        samp_cnt <= samp_cnt + 2'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bidir_pad_seq.sv
// Directed self-checking bench for bidir_pad_seq (TA_CYCLES=2 and TA_CYCLES=0 instances).
module tb_bidir_pad_seq;

`ifdef BIDIR_PAD_SEQ_SYNC_EN
    localparam int RD_LAT = 4;
`else
    localparam int RD_LAT = 2;
`endif

    logic       C = 1'b0;
    logic       R = 1'b1;

    logic       cmd_valid = 1'b0;
    logic       cmd_wr    = 1'b0;
    logic [7:0] cmd_data  = 8'h00;
    logic [7:0] pad_o     = 8'h00;
    logic       cmd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [7:0] pad_i;
    logic [7:0] pad_t;

    logic       cmd_valid0 = 1'b0;
    logic       cmd_wr0    = 1'b0;
    logic [7:0] cmd_data0  = 8'h00;
    logic [7:0] pad_o0     = 8'h00;
    logic       cmd_ready0;
    logic       rd_valid0;
    logic [7:0] rd_data0;
    logic [7:0] pad_i0;
    logic [7:0] pad_t0;

    int passed = 0;
    int total  = 0;

    always #5 C = ~C;

    bidir_pad_seq #(.WIDTH(8), .TA_CYCLES(2)) dut (
        .C         (C),
        .R         (R),
        .CMD_VALID (cmd_valid),
        .CMD_READY (cmd_ready),
        .CMD_WR    (cmd_wr),
        .CMD_DATA  (cmd_data),
        .RD_VALID  (rd_valid),
        .RD_DATA   (rd_data),
        .PAD_I     (pad_i),
        .PAD_T     (pad_t),
        .PAD_O     (pad_o)
    );

    bidir_pad_seq #(.WIDTH(8), .TA_CYCLES(0)) dut0 (
        .C         (C),
        .R         (R),
        .CMD_VALID (cmd_valid0),
        .CMD_READY (cmd_ready0),
        .CMD_WR    (cmd_wr0),
        .CMD_DATA  (cmd_data0),
        .RD_VALID  (rd_valid0),
        .RD_DATA   (rd_data0),
        .PAD_I     (pad_i0),
        .PAD_T     (pad_t0),
        .PAD_O     (pad_o0)
    );

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic test_reset();
        R = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (pad_t !== 8'hFF) $display("FAIL reset_pad_t cyc%0d: got %h expected ff", i, pad_t); else passed++;
            total++; if (pad_i !== 8'h00) $display("FAIL reset_pad_i cyc%0d: got %h expected 00", i, pad_i); else passed++;
            total++; if (cmd_ready !== 1'b0) $display("FAIL reset_ready cyc%0d: got %b expected 0", i, cmd_ready); else passed++;
            total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid cyc%0d: got %b expected 0", i, rd_valid); else passed++;
        end
        total++; if (pad_t0 !== 8'hFF) $display("FAIL reset_pad_t0: got %h expected ff", pad_t0); else passed++;
        R = 1'b0;
        tick();
        total++; if (cmd_ready !== 1'b1) $display("FAIL release_ready: got %b expected 1", cmd_ready); else passed++;
        total++; if (cmd_ready0 !== 1'b1) $display("FAIL release_ready0: got %b expected 1", cmd_ready0); else passed++;
    endtask

    task automatic test_write();
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_data = 8'hA5;
        tick();
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_data = 8'h00;
        total++; if (pad_t !== 8'h00) $display("FAIL wr_drive_pad_t: got %h expected 00", pad_t); else passed++;
        total++; if (pad_i !== 8'hA5) $display("FAIL wr_drive_pad_i: got %h expected a5", pad_i); else passed++;
        total++; if (cmd_ready !== 1'b0) $display("FAIL wr_drive_ready: got %b expected 0", cmd_ready); else passed++;
        for (int c = 2; c <= 3; c++) begin
            tick();
            total++; if (pad_t !== 8'hFF) $display("FAIL wr_ta_pad_t cyc%0d: got %h expected ff", c, pad_t); else passed++;
            total++; if (pad_i !== 8'hA5) $display("FAIL wr_ta_pad_i cyc%0d: got %h expected a5", c, pad_i); else passed++;
            total++; if (cmd_ready !== 1'b0) $display("FAIL wr_ta_ready cyc%0d: got %b expected 0", c, cmd_ready); else passed++;
        end
        tick();
        total++; if (cmd_ready !== 1'b1) $display("FAIL wr_done_ready: got %b expected 1", cmd_ready); else passed++;
        total++; if (pad_t !== 8'hFF) $display("FAIL wr_done_pad_t: got %h expected ff", pad_t); else passed++;
    endtask

    task automatic test_read();
        pad_o = 8'h3C;
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_data = 8'hEE;
        tick();
        cmd_valid = 1'b0;
        for (int c = 1; c <= RD_LAT + 1; c++) begin
            if (c > 1) tick();
            total++; if (rd_valid !== (c == RD_LAT)) $display("FAIL rd_valid cyc%0d: got %b expected %b", c, rd_valid, (c == RD_LAT)); else passed++;
            total++; if (pad_t !== 8'hFF) $display("FAIL rd_pad_t cyc%0d: got %h expected ff", c, pad_t); else passed++;
            if (c >= RD_LAT) begin
                total++; if (rd_data !== 8'h3C) $display("FAIL rd_data cyc%0d: got %h expected 3c", c, rd_data); else passed++;
            end
        end
        total++; if (cmd_ready !== 1'b1) $display("FAIL rd_done_ready: got %b expected 1", cmd_ready); else passed++;
    endtask

    task automatic test_back_to_back();
        int acc_edge = -1;
        int zeros    = 0;
        pad_o = 8'h3C;
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_data = 8'h5A;
        tick();
        cmd_wr = 1'b0; cmd_data = 8'h00;
        for (int i = 1; i <= 10; i++) begin
            if (i > 1) tick();
            if (acc_edge >= 0) cmd_valid = 1'b0;
            if (pad_t == 8'h00) zeros++;
            if (acc_edge < 0 && cmd_ready === 1'b1) acc_edge = i;
        end
        cmd_valid = 1'b0;
        total++; if (acc_edge !== 4) $display("FAIL b2b_read_accept_edge: got %0d expected 4", acc_edge); else passed++;
        total++; if (zeros !== 1) $display("FAIL b2b_drive_cycles: got %0d expected 1", zeros); else passed++;
        total++; if (rd_data !== 8'h3C) $display("FAIL b2b_rd_data: got %h expected 3c", rd_data); else passed++;
    endtask

    task automatic test_reset_in_sample();
        pad_o = 8'h3C;
        cmd_valid = 1'b1; cmd_wr = 1'b0;
        tick();
        cmd_valid = 1'b0;
        R = 1'b1;
        tick();
        R = 1'b0;
        total++; if (rd_valid !== 1'b0) $display("FAIL rst_samp_rd_valid: got %b expected 0", rd_valid); else passed++;
        total++; if (rd_data !== 8'h00) $display("FAIL rst_samp_rd_data: got %h expected 00", rd_data); else passed++;
        total++; if (pad_t !== 8'hFF) $display("FAIL rst_samp_pad_t: got %h expected ff", pad_t); else passed++;
        for (int c = 0; c < RD_LAT + 1; c++) begin
            tick();
            total++; if (rd_valid !== 1'b0) $display("FAIL rst_samp_no_pulse cyc%0d: got %b expected 0", c, rd_valid); else passed++;
        end
        total++; if (cmd_ready !== 1'b1) $display("FAIL rst_samp_ready: got %b expected 1", cmd_ready); else passed++;
    endtask

    task automatic test_ta_zero();
        cmd_valid0 = 1'b1; cmd_wr0 = 1'b1; cmd_data0 = 8'h01;
        tick();
        cmd_valid0 = 1'b0; cmd_wr0 = 1'b0; cmd_data0 = 8'h00;
        total++; if (pad_t0 !== 8'h00) $display("FAIL ta0_drive_pad_t: got %h expected 00", pad_t0); else passed++;
        total++; if (pad_i0 !== 8'h01) $display("FAIL ta0_drive_pad_i: got %h expected 01", pad_i0); else passed++;
        total++; if (cmd_ready0 !== 1'b0) $display("FAIL ta0_drive_ready: got %b expected 0", cmd_ready0); else passed++;
        tick();
        total++; if (pad_t0 !== 8'hFF) $display("FAIL ta0_after_pad_t: got %h expected ff", pad_t0); else passed++;
        total++; if (cmd_ready0 !== 1'b1) $display("FAIL ta0_after_ready: got %b expected 1", cmd_ready0); else passed++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_in_sample();
        test_ta_zero();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bidir_pad_seq.md
BIDIR_PAD_SEQ -- requirements
Module: bidir_pad_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: pad bus width in bits (1..32).
REQ-002 SHALL have parameter TA_CYCLES, default 2: turnaround cycles after a drive (0..15).
REQ-003 SHALL have port C  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port R  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port CMD_VALID  input  1  command request.
REQ-006 SHALL have port CMD_READY  output  1  command accept; transfer on CMD_VALID & CMD_READY at a rising edge of C.
REQ-007 SHALL have port CMD_WR  input  1  1 = write (drive pad), 0 = read (sample pad).
REQ-008 SHALL have port CMD_DATA  input  WIDTH  write data.
REQ-009 SHALL have port RD_VALID  output  1  one-cycle read-result strobe, no backpressure.
REQ-010 SHALL have port RD_DATA  output  WIDTH  read result; holds its value until the next RD_VALID.
REQ-011 SHALL have port PAD_I  output  WIDTH  data to the I pins of the tri-state IO buffers.
REQ-012 SHALL have port PAD_T  output  WIDTH  per-bit tri-state control to the T pins; 1 = high-Z, all bits always equal.
REQ-013 SHALL have port PAD_O  input  WIDTH  pad value from the O pins of the IO buffers.

Function
REQ-014 SHALL implement states IDLE, DRIVE, TA, SAMPLE, with every output registered.
REQ-015 SHALL assert CMD_READY only in IDLE.
REQ-016 SHALL, on a write accepted at edge k, enter DRIVE with PAD_I=CMD_DATA and PAD_T=0 for exactly one cycle, starting after edge k.
REQ-017 SHALL, after DRIVE, enter TA with PAD_T=1 and PAD_I held for TA_CYCLES cycles, then return to IDLE; with TA_CYCLES=0 it SHALL go DRIVE->IDLE directly.
REQ-018 SHALL, on a read accepted at edge k, enter SAMPLE for one cycle with PAD_T=1.
REQ-019 SHALL capture PAD_O into RD_DATA at the edge ending SAMPLE, pulse RD_VALID for one cycle, and return to IDLE.
REQ-020 SHALL guarantee that PAD_T is never 0 in the cycle immediately after a TA or SAMPLE cycle, other than through a new DRIVE entered from IDLE.
REQ-021 SHALL count TA cycles with a counter of width ceil(log2(TA_CYCLES+1)) that never wraps; the counter loads on DRIVE exit.
REQ-022 SHALL make back-to-back commands issue with a minimum spacing of 2+TA_CYCLES cycles (write) or 2 cycles (read), because each command returns to IDLE.
REQ-023 SHALL ignore CMD_WR and CMD_DATA when no transfer occurs.

Reset
REQ-024 SHALL, while R=1 at an edge, force state=IDLE, PAD_T=all 1, PAD_I=0, RD_DATA=0, RD_VALID=0, CMD_READY=0, TA counter=0.
REQ-025 SHALL assert CMD_READY=1 in the first cycle after R deasserts.
REQ-026 SHALL, when R is asserted mid-DRIVE, TA or SAMPLE, abort the command: the pending RD_VALID is not produced, and PAD_T returns to 1 after that edge.

Configuration
REQ-027 SHALL, when macro BIDIR_PAD_SEQ_SYNC_EN is defined, pass PAD_O through a 2-flop synchronizer and extend SAMPLE to 3 cycles, so RD_VALID comes 2 cycles later than without the macro.
REQ-028 SHALL, when BIDIR_PAD_SEQ_SYNC_EN is not defined, sample PAD_O directly with no synchronizer flops.

Structure
REQ-029 SHALL take the state encoding (2-bit enum) and the default WIDTH and TA_CYCLES constants from the shared package bidir_pad_seq_pkg.
REQ-030 SHALL implement the synchronizer as sub-module pad_sync (parameter WIDTH, ports C, R, D, Q; flops reset to 0), instantiated only under BIDIR_PAD_SEQ_SYNC_EN.

Verification
REQ-031 SHALL verify: reset held 3 cycles, then released -> PAD_T=0xFF and PAD_I=0x00 throughout reset; CMD_READY=1 in the first cycle after release.
REQ-032 SHALL verify: write 0xA5 accepted at edge 0 with TA_CYCLES=2 -> PAD_T=0x00 and PAD_I=0xA5 in cycle 1, PAD_T=0xFF in cycles 2-3, CMD_READY=1 in cycle 4.
REQ-033 SHALL verify: read accepted at edge 0 with PAD_O=0x3C -> RD_VALID=1 and RD_DATA=0x3C in cycle 2; with BIDIR_PAD_SEQ_SYNC_EN this happens in cycle 4.
REQ-034 SHALL verify: a write then a read with CMD_VALID held high -> the read is accepted exactly 4 cycles after the write, and PAD_T=0x00 for exactly one cycle.
REQ-035 SHALL verify: R asserted during SAMPLE -> no RD_VALID pulse, RD_DATA=0, and PAD_T=0xFF.
REQ-036 SHALL verify: TA_CYCLES=0 with a write of 0x01 -> PAD_T=0x00 in cycle 1 only, and CMD_READY=1 in cycle 2.
